// File: rtl/fpu_wb_pkg.sv
// Shared constants and types for the FP writeback arbiter slice.
package fpu_wb_pkg;

  localparam int N_SRC  = 16;
  localparam int SEL_W  = 4;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef logic [SEL_W-1:0] wb_sel_t;
  typedef logic [RD_W-1:0]  wb_rd_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/fpu_wb_arbiter_rr.sv
// 16-way round-robin grant search: lowest requester at or after ptr, wrapping.
module rr_arbiter_16
  import fpu_wb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  wb_sel_t          ptr,
  output logic [N_SRC-1:0] gnt_onehot,
  output wb_sel_t          gnt_idx,
  output logic             any
);

  wb_sel_t idx;
  logic    found;

  // Scan from ptr upward; the 4-bit index wraps 15 -> 0 on its own.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Round-robin collector of FP32 unit results into a one-entry writeback register.
module fpu_wb_arbiter #(
  parameter int N_SRC  = 16,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*RD_W-1:0]   src_rd,
  output logic [N_SRC-1:0]        src_ready,
  output logic [3:0]              mux_sel,
  input  logic [DATA_W-1:0]       mux_y,
  input  logic                    flush,
  output logic                    wb_valid,
  output logic [DATA_W-1:0]       wb_data,
  output logic [RD_W-1:0]         wb_rd,
  input  logic                    wb_ready
);
  import fpu_wb_pkg::*;

  wb_state_t         state_p1;
  logic [DATA_W-1:0] wb_data_p1;
  logic [RD_W-1:0]   wb_rd_p1;
  wb_sel_t           rr_ptr;

  logic [N_SRC-1:0]  gnt_onehot;
  wb_sel_t           gnt_idx;
  logic              any_req;
  logic              can_load;
  logic              accept;
  logic [RD_W-1:0]   gnt_rd;

  rr_arbiter_16 u_rr (
    .req        (src_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  // rst_n gates the handshake so nothing is offered while reset is held.
  assign can_load  = rst_n && ((state_p1 == EMPTY) || wb_ready) && !flush;
  assign accept    = any_req && can_load;
  assign src_ready = accept ? gnt_onehot : '0;
  assign mux_sel   = !rst_n ? '0 : (any_req ? gnt_idx : rr_ptr);
  assign gnt_rd    = src_rd[int'(gnt_idx)*RD_W +: RD_W];

  // Writeback register stage: flush wins, then load, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1   <= EMPTY;
      wb_data_p1 <= '0;
      wb_rd_p1   <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      state_p1 <= EMPTY;
    end else if (accept) begin
      state_p1   <= FULL;
      wb_data_p1 <= mux_y;
      wb_rd_p1   <= gnt_rd;
      rr_ptr     <= gnt_idx + 4'd1;
    end else if ((state_p1 == FULL) && wb_ready) begin
      state_p1 <= EMPTY;
    end
  end

  assign wb_valid = (state_p1 == FULL);
  assign wb_data  = wb_data_p1;
  assign wb_rd    = wb_rd_p1;

endmodule

// File: doc/fpu_wb_arbiter.md
# fpu_wb_arbiter

- Collects results from up to 16 FP32 functional-unit sources and picks one per cycle by round-robin.
- Drives the 4-bit select of the 32-bit 16:1 result multiplexer (`mux_16X1_32bit`) and captures that multiplexer's output, with the winner's destination register, into a one-entry writeback register.
- Presents the writeback register to the FP register-file write port through a valid/ready handshake.
- Sits directly upstream of the result multiplexer (select side) and directly downstream of it (data side).

## Interface
Parameters:
- N_SRC, 16, number of sources; fixed at 16 to match the 4-bit mux select.
- DATA_W, 32, result width.
- RD_W, 5, destination FP register index width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- src_valid  input  16  bit i set: source i holds a result.
- src_rd  input  16*RD_W  destination index of source i, at bits [i*RD_W +: RD_W].
- src_ready  output  16  one-hot; bit i set means source i's result is taken this cycle.
- mux_sel  output  4  select to the external 16:1 result mux.
- mux_y  input  DATA_W  output of that mux; its value equals source data at index mux_sel.
- flush  input  1  pipeline flush; discards the held writeback and blocks grants.
- wb_valid  output  1  writeback register holds a result.
- wb_data  output  DATA_W  held result.
- wb_rd  output  RD_W  held destination index.
- wb_ready  input  1  register file accepts wb_data this cycle.

## Operation
Output-register state machine, two states:
- EMPTY (wb_valid=0).
- FULL (wb_valid=1).

Definitions:
- can_load = (EMPTY or wb_ready) and not flush.
- Grant search: the lowest index at or after rr_ptr, wrapping modulo 16, whose src_valid bit is set.
- any_req = OR of src_valid.
- mux_sel = grant index when any_req, otherwise rr_ptr.

Accept occurs when any_req and can_load. On accept:
- src_ready[grant]=1; all other bits 0.
- wb_data <= mux_y, wb_rd <= src_rd[grant], wb_valid <= 1.
- rr_ptr <= grant+1 modulo 16; 15 wraps to 0.

No accept:
- src_ready is all zeros.
- rr_ptr is unchanged.
- If FULL and wb_ready: go to EMPTY (wb_valid <= 0).
- If FULL and not wb_ready: wb_data and wb_rd are held stable.

flush:
- wb_valid <= 0 next cycle, regardless of wb_ready.
- No grant that cycle; rr_ptr unchanged.
- Flush has priority over every other event.

Other boundary rules:
- FULL with wb_ready and a new request in the same cycle: drain and reload together, with no bubble.
- A source must keep src_valid and its data stable until it sees src_ready. The block never takes a source that is not valid.

## Timing
- Reset values: wb_valid=0, wb_data=0, wb_rd=0, rr_ptr=0, state EMPTY.
- Outputs during reset: src_ready all zeros, mux_sel=0.
- src_ready and mux_sel are combinational from src_valid, rr_ptr, state, wb_ready and flush. No combinational path exists from mux_y to any output.
- Latency: one cycle. A result accepted at edge k appears on wb_* after edge k.
- Throughput: one result per cycle while wb_ready stays high.
- Reset asserted mid-transfer: all state clears immediately, and any held result is lost.
- Fairness: a continuously valid source waits at most 15 grants.

## Structure
Package fpu_wb_pkg holds:
- N_SRC=16, SEL_W=4, DATA_W=32, RD_W=5.
- typedef wb_sel_t (logic [SEL_W-1:0]).
- typedef wb_rd_t.

Sub-module rr_arbiter_16:
- Combinational.
- Inputs: req[15:0], ptr[3:0].
- Outputs: gnt_onehot[15:0], gnt_idx[3:0], any.

The top level holds the pointer, the state machine and the writeback register. The 32-bit result mux stays outside this block and is instantiated alongside it.

## Test plan
- Reset, then single request: src_valid=16'h0008, src_rd[3]=7, mux_y=32'h3F800000 → mux_sel=3 and src_ready=16'h0008 that cycle; next cycle wb_valid=1, wb_data=32'h3F800000, wb_rd=7; rr_ptr becomes 4.
- Round-robin wrap: src_valid=16'h8001 held, wb_ready=1, rr_ptr=0 → grants 0, 15, 0, 15 on consecutive cycles; after granting 15, rr_ptr wraps to 0.
- Back-pressure: FULL with wb_ready=0 for 3 cycles while src_valid=16'h0010 → src_ready stays 0 and wb_data stays stable; when wb_ready=1, src_ready[4]=1 in that same cycle and the new value loads with no bubble.
- Flush: FULL, src_valid=16'h0002, flush=1, wb_ready=0 → src_ready=0 and next cycle wb_valid=0; the following cycle (flush=0) grants source 1.
- Reset mid-stream: rst_n dropped asynchronously while FULL with src_valid=16'hFFFF → wb_valid, wb_data and src_ready go to 0 immediately, before the next edge; after release, the first grant is index 0.
- Fairness soak: src_valid=16'hFFFF held for 32 cycles with wb_ready=1 → each source is granted exactly twice, in order 0 through 15 and again.
